// File: rtl/ocm_stream_mover_pkg.sv
// ocm_stream_mover_pkg
// Shared types and constants for the on-chip memory stream mover.
//   state_t      : command FSM states
//   DEF_*        : default parameter values for the mover
//   BE_ALL()     : all-ones byteenable mask for a given number of bytes
package ocm_stream_mover_pkg;

  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    FIN
  } state_t;

  // Returns a mask with the low n_bytes bits set; callers truncate to
  // their own byteenable width.
  function automatic logic [31:0] BE_ALL(input int n_bytes);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n_bytes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/ocm_rd_pipe.sv
// ocm_rd_pipe
// Valid-bit shift register that follows each read issue through the
// memory read latency. It advances only while the memory is clock-enabled,
// so it stays aligned with the memory's own pipeline under back-pressure.
// Ports:
//   clk_clk     : system clock
//   reset_reset : synchronous active-high flush
//   enable      : advance the pipeline (tied to mem_clken)
//   in_valid    : a read issue is being registered this edge
//   tail_valid  : read data for the oldest issue is on mem_readdata
module ocm_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic enable,
  input  logic in_valid,
  output logic tail_valid
);

  logic [DEPTH-1:0] pipe;

  // Stage 0 is loaded at the same edge as the issue registers, so the tail
  // lines up with the data the memory returns.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pipe <= '0;
    end else if (enable) begin
      pipe <= {pipe[DEPTH-2:0], in_valid};
    end
  end

  assign tail_valid = pipe[DEPTH-1];

endmodule

// File: rtl/ocm_stream_mover.sv
// ocm_stream_mover
// Avalon-MM master for the hps_system on-chip memory s1 port. A command
// moves len consecutive words either from the ingress stream into memory
// (cmd_write = 1) or from memory onto the egress stream (cmd_write = 0).
// Ports:
//   clk_clk, reset_reset            : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len  : command handshake and parameters
//   wr_data/valid/ready             : ingress stream (to memory)
//   rd_data/valid/ready             : egress stream (from memory)
//   busy, done, err                 : status; done/err are one-cycle pulses
//   mem_*                           : s1 slave port signals
// Build option: define OCM_STREAM_MOVER_WRAP_EN to drop the range check and
// let the word address wrap modulo 2^ADDR_W (err is then always 0).
module ocm_stream_mover
  import ocm_stream_mover_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_clken,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0]   BE_MASK   = BE_W'(BE_ALL(BE_W));
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};

  state_t            state, next_state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   rd_left;
  logic              accept, wr_hs, rd_hs, range_bad, issue_in;

  // Stalling the memory while a word waits on the egress port freezes the
  // whole read path, so nothing is lost and no skid buffer is needed.
  assign mem_clken = !(rd_valid && !rd_ready);
  assign rd_data   = mem_readdata;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= next_state;
  end

  // Handshake decode and next-state selection.
  always_comb begin
    next_state = state;
    accept     = (state == IDLE) && cmd_valid && cmd_ready;
    wr_hs      = (state == WRITE) && wr_valid && wr_ready;
    rd_hs      = (state == READ) && rd_valid && rd_ready;
`ifdef OCM_STREAM_MOVER_WRAP_EN
    range_bad  = 1'b0;
`else
    range_bad  = ({2'b00, cmd_addr} + {1'b0, cmd_len}) > MEM_WORDS;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0 || range_bad) next_state = FIN;
          else if (cmd_write)             next_state = WRITE;
          else                            next_state = READ;
        end
      end
      WRITE:   if (wr_hs && remaining == CNT_ONE) next_state = FIN;
      READ:    if (rd_hs && rd_left == CNT_ONE)   next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // A read issue is registered at the accept edge and then on every
    // enabled edge until all words have been issued.
    issue_in = ((state == IDLE) && (next_state == READ)) ||
               ((state == READ) && (remaining != '0));
  end

  // Status outputs, counters and the registered s1 master signals.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cmd_ready      <= 1'b0;
      wr_ready       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cur            <= '0;
      remaining      <= '0;
      rd_left        <= '0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      wr_ready  <= (next_state == WRITE);
      busy      <= (next_state == WRITE) || (next_state == READ);
      done      <= (next_state == FIN);
      err       <= accept && range_bad;
      case (state)
        IDLE: begin
          mem_chipselect <= 1'b0;
          mem_write      <= 1'b0;
          if (accept) begin
            cur       <= cmd_addr;
            remaining <= cmd_len;
            rd_left   <= cmd_len;
            if (next_state == READ) begin
              mem_chipselect <= 1'b1;
              mem_address    <= cmd_addr;
              mem_byteenable <= BE_MASK;
              cur            <= cmd_addr + ADDR_ONE;
              remaining      <= cmd_len - CNT_ONE;
            end
          end
        end
        WRITE: begin
          mem_chipselect <= wr_hs;
          mem_write      <= wr_hs;
          if (wr_hs) begin
            mem_address    <= cur;
            mem_writedata  <= wr_data;
            mem_byteenable <= BE_MASK;
            cur            <= cur + ADDR_ONE;
            remaining      <= remaining - CNT_ONE;
          end
        end
        READ: begin
          if (rd_hs) rd_left <= rd_left - CNT_ONE;
          if (mem_clken) begin
            mem_write <= 1'b0;
            if (remaining != '0) begin
              mem_chipselect <= 1'b1;
              mem_address    <= cur;
              cur            <= cur + ADDR_ONE;
              remaining      <= remaining - CNT_ONE;
            end else begin
              mem_chipselect <= 1'b0;
            end
          end
        end
        default: begin
          mem_chipselect <= 1'b0;
          mem_write      <= 1'b0;
        end
      endcase
    end
  end

  ocm_rd_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_rd_pipe (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .enable      (mem_clken),
    .in_valid    (issue_in),
    .tail_valid  (rd_valid)
  );

endmodule
